// File: rtl/branch_resolve_if.sv
// branch_resolve_if
//   Bundles the execute-stage inputs and the fetch-redirect outputs of the
//   branch resolver so that the pipeline and IR_fetch glue can be connected
//   in a single port.
//
//   Signals (direction as seen by the resolver, modport slave):
//     stall               in   freeze the resolver this cycle
//     branch_e            in   execute-stage instruction is a branch
//     branch_condition_e  in   4-bit condition code
//     branch_offset_e     in   12-bit PC-relative target offset
//     flag_write_e        in   execute-stage instruction writes flags
//     alu_n/z/c/v         in   ALU result flags
//     PC_source           out  1 = IR_fetch takes the PC+offset path
//     PC_offset           out  offset presented to IR_fetch
//     flush               out  squash decode/execute pipeline registers
//     flags               out  registered {N,Z,C,V}
//     taken_count         out  taken branches since reset
//
//   modport master is the upstream/pipeline side that drives the inputs.
interface branch_resolve_if #(
  parameter int COUNT_WIDTH = 16
);
  logic                   stall;
  logic                   branch_e;
  logic [3:0]             branch_condition_e;
  logic [11:0]            branch_offset_e;
  logic                   flag_write_e;
  logic                   alu_n;
  logic                   alu_z;
  logic                   alu_c;
  logic                   alu_v;
  logic                   PC_source;
  logic [11:0]            PC_offset;
  logic                   flush;
  logic [3:0]             flags;
  logic [COUNT_WIDTH-1:0] taken_count;

  modport master (
    output stall, branch_e, branch_condition_e, branch_offset_e,
           flag_write_e, alu_n, alu_z, alu_c, alu_v,
    input  PC_source, PC_offset, flush, flags, taken_count
  );

  modport slave (
    input  stall, branch_e, branch_condition_e, branch_offset_e,
           flag_write_e, alu_n, alu_z, alu_c, alu_v,
    output PC_source, PC_offset, flush, flags, taken_count
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Execute-stage branch resolver. Keeps the architectural {N,Z,C,V} flags,
//   evaluates the branch condition against them and, on a taken branch,
//   redirects IR_fetch for one cycle and then holds flush for a total of
//   FLUSH_CYCLES cycles (redirect cycle included) to squash the wrong path.
//
//   Parameters:
//     FLUSH_CYCLES  cycles flush stays high per taken branch, legal 1..7
//     COUNT_WIDTH   width of taken_count
//
//   Ports:
//     clock    system clock, rising edge
//     reset_n  synchronous active-low reset
//     bus      branch_resolve_if.slave (see interface header)
module branch_resolve_unit #(
  parameter int FLUSH_CYCLES = 2,
  parameter int COUNT_WIDTH  = 16
) (
  input logic             clock,
  input logic             reset_n,
  branch_resolve_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    SQUASH   = 2'd2
  } state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  state_t                 r_state;
  state_t                 w_stateNext;
  logic                   r_pcSource;
  logic                   w_pcSourceNext;
  logic [11:0]            r_pcOffset;
  logic [11:0]            w_pcOffsetNext;
  logic                   r_flush;
  logic                   w_flushNext;
  logic [3:0]             r_flags;
  logic [3:0]             w_flagsNext;
  logic [COUNT_WIDTH-1:0] r_takenCount;
  logic [COUNT_WIDTH-1:0] w_takenCountNext;
  logic [2:0]             r_counter;
  logic [2:0]             w_counterNext;
  logic                   w_condTrue;
  logic                   w_n;
  logic                   w_z;
  logic                   w_c;
  logic                   w_v;

  // Conditions always look at the registered flags, so a flag-writing
  // instruction paired with a branch in the same cycle does not affect it.
  assign {w_n, w_z, w_c, w_v} = r_flags;

  // Condition code decode.
  always_comb begin
    w_condTrue = 1'b0;
    case (bus.branch_condition_e)
      4'h0: w_condTrue = w_z;
      4'h1: w_condTrue = !w_z;
      4'h2: w_condTrue = w_c;
      4'h3: w_condTrue = !w_c;
      4'h4: w_condTrue = w_n;
      4'h5: w_condTrue = !w_n;
      4'h6: w_condTrue = w_v;
      4'h7: w_condTrue = !w_v;
      4'h8: w_condTrue = w_c && !w_z;
      4'h9: w_condTrue = !w_c || w_z;
      4'hA: w_condTrue = (w_n == w_v);
      4'hB: w_condTrue = (w_n != w_v);
      4'hC: w_condTrue = !w_z && (w_n == w_v);
      4'hD: w_condTrue = w_z || (w_n != w_v);
      4'hE: w_condTrue = 1'b1;
      default: w_condTrue = 1'b0;
    endcase
  end

  // Next-state logic. Everything holds by default, which is also how a
  // stall freezes the unit; wrong-path branches and flag writes are simply
  // not looked at outside IDLE.
  always_comb begin
    w_stateNext      = r_state;
    w_pcSourceNext   = r_pcSource;
    w_pcOffsetNext   = r_pcOffset;
    w_flushNext      = r_flush;
    w_flagsNext      = r_flags;
    w_takenCountNext = r_takenCount;
    w_counterNext    = r_counter;
    if (!bus.stall) begin
      case (r_state)
        IDLE: begin
          if (bus.flag_write_e)
            w_flagsNext = {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
          if (bus.branch_e && w_condTrue) begin
            w_pcSourceNext   = 1'b1;
            w_pcOffsetNext   = bus.branch_offset_e;
            w_flushNext      = 1'b1;
            w_takenCountNext = r_takenCount + COUNT_WIDTH'(1);
            w_counterNext    = FLUSH_INIT;
            w_stateNext      = REDIRECT;
          end
        end
        REDIRECT: begin
          w_pcSourceNext = 1'b0;
          if (r_counter == 3'd0) begin
            w_flushNext = 1'b0;
            w_stateNext = IDLE;
          end else begin
            w_stateNext = SQUASH;
          end
        end
        SQUASH: begin
          // The counter still holds the squash cycles left including this
          // one, so flush drops on the edge where it steps from 1 to 0.
          w_counterNext = r_counter - 3'd1;
          if (r_counter == 3'd1) begin
            w_flushNext = 1'b0;
            w_stateNext = IDLE;
          end
        end
        default: begin
          w_pcSourceNext = 1'b0;
          w_flushNext    = 1'b0;
          w_counterNext  = 3'd0;
          w_stateNext    = IDLE;
        end
      endcase
    end
  end

  // State register; reset takes priority over stall and any redirect/squash.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_pcSource   <= 1'b0;
      r_pcOffset   <= 12'd0;
      r_flush      <= 1'b0;
      r_flags      <= 4'd0;
      r_takenCount <= '0;
      r_counter    <= 3'd0;
    end else begin
      r_state      <= w_stateNext;
      r_pcSource   <= w_pcSourceNext;
      r_pcOffset   <= w_pcOffsetNext;
      r_flush      <= w_flushNext;
      r_flags      <= w_flagsNext;
      r_takenCount <= w_takenCountNext;
      r_counter    <= w_counterNext;
    end
  end

  assign bus.PC_source   = r_pcSource;
  assign bus.PC_offset   = r_pcOffset;
  assign bus.flush       = r_flush;
  assign bus.flags       = r_flags;
  assign bus.taken_count = r_takenCount;

endmodule
